// File: rtl/rv_lsu.sv
// rv_lsu -- load/store unit of the RV32IM core.
//
// Takes one load or store at a time from the execute stage and issues it to
// the data port of rv_memory_unit over a valid/ready handshake. The memory
// has no byte enables, so byte and half-word stores are done as a
// read-modify-write: read the word, merge the new lane(s), write it back.
// Loaded bytes and half-words are extracted and sign- or zero-extended.
// Misaligned accesses and illegal funct3 values complete immediately with
// resp_err_o and never touch memory.
//
// Ports:
//   clk_i, arst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only when idle)
//   req_we_i                 1 = store, 0 = load
//   req_funct3_i             RISC-V funct3 (access size and signedness)
//   req_addr_i               byte address
//   req_wdata_i              store data (rs2)
//   resp_valid_o             one-cycle completion pulse
//   resp_rdata_o             extended load data (0 for stores and errors)
//   resp_err_o               misaligned / illegal funct3, valid with resp_valid_o
//   mem_valid_o/mem_ready_i  data port handshake
//   mem_addr_o               word index (WORD_ADDR=1) or word-aligned byte address
//   mem_wdata_o, mem_write_o write data and direction, held for the whole access
//   mem_rdata_i              read data, sampled in the ready cycle
module rv_lsu #(
  parameter int XLEN      = 32,
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_write_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Request fields latched at acceptance. Only the low address bits and the
  // low half of the store data are needed after acceptance: the word address
  // goes straight into mem_addr_reg and a full-word store's data straight
  // into mem_wdata_reg.
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [1:0]      addr_lo_reg;
  logic [15:0]     wdata_lo_reg;
  logic            err_reg;
  logic [XLEN-1:0] rdata_reg;
  logic [XLEN-1:0] mem_addr_reg;
  logic [XLEN-1:0] mem_wdata_reg;
  logic            mem_write_reg;

  logic            req_accept;
  logic            req_legal;
  logic            req_misaligned;
  logic            req_err;
  logic            req_is_sw;
  logic [XLEN-1:0] req_mem_addr;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic            load_sign;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_wdata;

  // ---------------------------------------------------------------- decode
  assign req_accept = req_valid_i && (state_reg == IDLE);

  always_comb begin
    req_legal = 1'b0;
    if (req_we_i) begin
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
  end

  assign req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign req_err        = !req_legal || req_misaligned;
  // A legal full-word store skips the read and goes straight to WRITE.
  assign req_is_sw      = req_we_i && (req_funct3_i == 3'b010) && !req_err;
  assign req_mem_addr   = WORD_ADDR ? (req_addr_i >> 2) : {req_addr_i[XLEN-1:2], 2'b00};

  // ---------------------------------------------------------- load extract
  assign load_byte = mem_rdata_i[{addr_lo_reg, 3'b000} +: 8];
  assign load_half = addr_lo_reg[1] ? mem_rdata_i[16 +: 16] : mem_rdata_i[0 +: 16];

  always_comb begin
    load_sign = 1'b0;
    load_data = mem_rdata_i;
    case (funct3_reg[1:0])
      2'b00: begin
        load_sign = !funct3_reg[2] && load_byte[7];
        load_data = {{(XLEN-8){load_sign}}, load_byte};
      end
      2'b01: begin
        load_sign = !funct3_reg[2] && load_half[15];
        load_data = {{(XLEN-16){load_sign}}, load_half};
      end
      default: load_data = mem_rdata_i;
    endcase
  end

  // -------------------------------------------------- RMW lane merge
  // funct3_reg[0] separates SH (two lanes picked by addr[1]) from SB (one
  // lane picked by addr[1:0]). A half-word store puts its low byte in the
  // even lane and its high byte in the odd lane.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic       lane_sel;
    logic [7:0] store_byte;

    assign lane_sel   = funct3_reg[0] ? (addr_lo_reg[1] == 1'(gi / 2))
                                      : (addr_lo_reg == 2'(gi));
    assign store_byte = funct3_reg[0] ? wdata_lo_reg[8*(gi % 2) +: 8]
                                      : wdata_lo_reg[7:0];
    assign merged_wdata[8*gi +: 8] = lane_sel ? store_byte : mem_rdata_i[8*gi +: 8];
  end

  // ------------------------------------------------------ state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_lo_reg   <= 2'b00;
      wdata_lo_reg  <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (req_accept) begin
            we_reg        <= req_we_i;
            funct3_reg    <= req_funct3_i;
            addr_lo_reg   <= req_addr_i[1:0];
            wdata_lo_reg  <= req_wdata_i[15:0];
            err_reg       <= req_err;
            mem_addr_reg  <= req_mem_addr;
            mem_write_reg <= req_is_sw;
            if (req_is_sw) begin
              mem_wdata_reg <= req_wdata_i;
            end
            if (req_err) begin
              rdata_reg <= '0;
            end
          end
        end
        READ: begin
          if (mem_ready_i) begin
            if (we_reg) begin
              // Direction flips only after the read's ready cycle.
              mem_wdata_reg <= merged_wdata;
              mem_write_reg <= 1'b1;
            end else begin
              rdata_reg <= load_data;
            end
          end
        end
        WRITE: begin
          if (mem_ready_i) begin
            mem_write_reg <= 1'b0;
            rdata_reg     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------- next state and outputs
  always_comb begin
    state_next   = state_reg;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    mem_valid_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_accept) begin
          if (req_err) begin
            state_next = DONE;
          end else if (req_is_sw) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        // Valid drops in the ready cycle so the responder cannot re-arm on a
        // level-sensitive valid.
        mem_valid_o = !mem_ready_i;
        if (mem_ready_i) begin
          state_next = we_reg ? WRITE : DONE;
        end
      end
      WRITE: begin
        mem_valid_o = !mem_ready_i;
        if (mem_ready_i) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_reg;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_rdata_o = rdata_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_wdata_o  = mem_wdata_reg;
  assign mem_write_o  = mem_write_reg;

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
Load/store unit of the RV32IM core. It is the initiator on the data port of rv_memory_unit. It accepts one load or store from the execute stage and checks alignment and funct3. It converts the byte address to a word index and drives the valid/ready data handshake. Byte and half-word stores are done as read-modify-write because the memory has no byte enables. Loaded bytes and half-words are extracted and sign- or zero-extended.

Parameters:
WORD_ADDR, 1, 1: mem_addr_o = req_addr >> 2 (word index, as used by rv_memory_unit); 0: mem_addr_o = {req_addr[XLEN-1:2], 2'b00}
XLEN, from rv_pkg, data/address width (32)

Ports:
clk_i  input  1  clock
arst_i  input  1  asynchronous reset, active-high
req_valid_i  input  1  execute stage presents a request
req_ready_o  output  1  LSU idle; request accepted when req_valid_i && req_ready_o
req_we_i  input  1  1 = store, 0 = load
req_funct3_i  input  3  RISC-V funct3 (size/sign)
req_addr_i  input  XLEN  byte address
req_wdata_i  input  XLEN  store data (rs2)
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  XLEN  extended load result (0 for stores and errors)
resp_err_o  output  1  valid with resp_valid_o; misaligned or illegal funct3
mem_valid_o  output  1  to data_valid_i
mem_ready_i  input  1  from data_ready_o
mem_addr_o  output  XLEN  to data_addr_i
mem_wdata_o  output  XLEN  to data_wdata_i
mem_write_o  output  1  to data_write_i
mem_rdata_i  input  XLEN  from data_rdata_o

Behaviour:
- Reset (arst_i high, async): state = IDLE. req_ready_o = 1 after reset release. resp_valid_o = 0, resp_err_o = 0, resp_rdata_o = 0, mem_valid_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, all latches cleared.
- Reset mid-transaction drops the request with no response. A later mem_ready_i seen in IDLE or DONE is ignored.
- States: IDLE, READ, WRITE, DONE.
- IDLE: req_ready_o = 1; in every other state req_ready_o = 0. On acceptance, latch we, funct3, addr and wdata.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 → err.
- Misaligned → err: half-word with addr[0] = 1, or word with addr[1:0] != 0.
- Transitions out of IDLE on acceptance:
  - err → DONE.
  - load → READ.
  - SW → WRITE.
  - SB/SH → READ (RMW).
- READ: mem_valid_o = !mem_ready_i, mem_write_o = 0. On mem_ready_i:
  - Load: select the byte/half at addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU. Register into resp_rdata_o, go to DONE.
  - RMW: merge the store byte/half into mem_rdata_i at the lane given by addr[1:0] (byte: 8·addr[1:0]; half: 16·addr[1]). Register the result as mem_wdata_o, go to WRITE.
- WRITE: mem_valid_o = !mem_ready_i, mem_write_o = 1. On mem_ready_i go to DONE.
- DONE: resp_valid_o = 1 for exactly one cycle, resp_err_o as latched, then → IDLE.
- mem_valid_o is combinationally low in any cycle where mem_ready_i = 1. This prevents the responder re-arming on a level valid.
- mem_addr_o, mem_wdata_o and mem_write_o are registered and held stable from the first mem_valid_o cycle until mem_ready_i, because the responder samples them at completion.
- mem_write_o is 0 in IDLE and READ; the READ→WRITE transition changes it only after the read's ready cycle.
- Timing, with the request accepted in cycle A and final mem_ready_i in cycle R:
  - First mem_valid_o in A+1.
  - resp_valid_o in R+1.
  - req_ready_o = 1 again in R+2.
  - Error path: resp_valid_o in A+1, no mem_valid_o at all.
- RMW issues two memory transactions, and WRITE starts the cycle after the read's ready.
- req_valid_i while busy is ignored; the request is not latched.
- resp_rdata_o holds its value between responses.

Test Plan:
1. Memory word index 4 = 0x8081F2F3 (byte address 0x10).
   - LB 0x13 → resp_rdata_o 0xFFFFFF80, err 0.
   - LBU 0x13 → 0x00000080.
   - LH 0x12 → 0xFFFF8081.
   - LHU 0x10 → 0x0000F2F3.
   - LW 0x10 → 0x8081F2F3.
   - Each load: mem_addr_o = 4 and exactly one memory transaction.
2. SB 0x11, wdata 0x000000AA onto 0x8081F2F3:
   - One read, then one write with mem_write_o = 1 and mem_wdata_o = 0x8081AAF3.
   - A following LW 0x10 returns 0x8081AAF3.
3. SW 0x20, wdata 0xDEADBEEF:
   - A single write to index 8, no read.
   - resp_valid_o exactly one cycle after mem_ready_i.
   - mem_valid_o low in the ready cycle, and the responder is not re-triggered.
4. Error requests:
   - LW 0x12, SH 0x11, and funct3 = 011 load each give resp_valid_o with resp_err_o = 1 in cycle A+1.
   - mem_valid_o never asserts.
5. Assert arst_i during WRITE of an SB, with mem_ready_i arriving afterwards:
   - Outputs return to reset values.
   - No resp_valid_o is produced.
   - The next LW completes normally.
6. Hold req_valid_i high for back-to-back LWs at 0x0 and 0x4:
   - The second request is accepted only in cycle R+2.
   - Two distinct responses, no request lost or duplicated.
